// File: rtl/ddr4_dll_lock_ctrl.sv
// Fabric-side lock/update controller for the DDR4 DLL wrapper: power-up sequencing,
// filtered lock qualification with timeout/retry, code capture and code-update pulses.
module ddr4_dll_lock_ctrl #(
  parameter int unsigned PWRUP_CYCLES    = 64,
  parameter int unsigned LOCK_FILTER     = 8,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned UPDATE_INTERVAL = 1024,
  parameter int unsigned UPDATE_PULSE    = 4,
  parameter int unsigned CAPTURE_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       FORCE_UPDATE,
  input  logic       DLL_LOCK,
  input  logic       DLL_DELAY_DIFF,
  input  logic [7:0] DLL_CODE,
  output logic       DLL_POWERDOWN_N,
  output logic       DLL_CODE_UPDATE,
  output logic       READY,
  output logic [7:0] CODE_OUT,
  output logic       CODE_VALID,
  output logic       ERROR,
  output logic [1:0] RETRY_CNT,
  output logic [2:0] STATE
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One state timer serves every timed state, so it is sized for the longest interval.
  localparam int unsigned TMR_MAX = max2(max2(max2(PWRUP_CYCLES, LOCK_TIMEOUT),
                                              max2(UPDATE_INTERVAL, UPDATE_PULSE)),
                                         CAPTURE_TIMEOUT);
  localparam int unsigned TW = $clog2(TMR_MAX) + 1;
  localparam int unsigned FW = $clog2(LOCK_FILTER) + 1;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWRUP     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_LOCKED    = 3'd3,
    S_UPDATE    = 3'd4,
    S_CAPTURE   = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            lock_s1, lock_sync, diff_s1, diff_sync;
  logic [7:0]      code_s, code_p;
  logic [TW-1:0]   tmr_q, tmr_d, tmr_inc;
  logic [FW-1:0]   filt_q, filt_d, filt_inc;
  logic [1:0]      retry_d, retry_inc;
  logic [7:0]      code_out_d;
  logic            code_valid_d, pdn_d, upd_d, rdy_d, err_d;
  logic            retry_ok, wrap, code_match;
  state_t          retry_state;

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    retry_d      = RETRY_CNT;
    code_out_d   = CODE_OUT;
    code_valid_d = 1'b0;

    tmr_inc     = (tmr_q == TW'(TMR_MAX)) ? tmr_q : tmr_q + TW'(1);
    filt_inc    = !lock_sync ? '0 :
                  (filt_q == FW'(LOCK_FILTER)) ? filt_q : filt_q + FW'(1);
    retry_ok    = (RETRY_CNT < 2'(MAX_RETRY));
    retry_state = retry_ok ? S_PWRUP : S_FAIL;
    retry_inc   = retry_ok ? RETRY_CNT + 2'd1 : RETRY_CNT;
    wrap        = (tmr_q == TW'(UPDATE_INTERVAL - 1));
    code_match  = (tmr_q != '0) && (code_s == code_p);

    case (state_q)
      S_OFF: begin
        if (ENABLE) state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (tmr_q == TW'(PWRUP_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock qualification wins over a coincident timeout.
        if (filt_inc == FW'(LOCK_FILTER)) begin
          state_d = S_CAPTURE;
        end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end
      end
      S_CAPTURE: begin
        if (!lock_sync) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end else if (code_match) begin
          state_d      = S_LOCKED;
          code_out_d   = code_s;
          code_valid_d = 1'b1;
          retry_d      = 2'd0;
        end else if (tmr_q == TW'(CAPTURE_TIMEOUT - 1)) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (!lock_sync) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end else if (FORCE_UPDATE || (wrap && diff_sync)) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!lock_sync) begin
          state_d = retry_state;
          retry_d = retry_inc;
        end else if (tmr_q == TW'(UPDATE_PULSE - 1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    // Disable overrides everything except reset; the captured code survives.
    if (!ENABLE) begin
      state_d      = S_OFF;
      retry_d      = 2'd0;
      code_out_d   = CODE_OUT;
      code_valid_d = 1'b0;
    end

    if (state_d != state_q) tmr_d = '0;
    else if (state_q == S_LOCKED && wrap) tmr_d = '0;
    else tmr_d = tmr_inc;

    filt_d = (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) ? filt_inc : '0;

    pdn_d = (state_d inside {S_WAIT_LOCK, S_LOCKED, S_UPDATE, S_CAPTURE});
    upd_d = (state_d == S_UPDATE);
    rdy_d = (state_d == S_LOCKED);
    err_d = (state_d == S_FAIL);
  end

  // State, synchronizers, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= S_OFF;
      lock_s1         <= 1'b0;
      lock_sync       <= 1'b0;
      diff_s1         <= 1'b0;
      diff_sync       <= 1'b0;
      code_s          <= 8'h00;
      code_p          <= 8'h00;
      tmr_q           <= '0;
      filt_q          <= '0;
      DLL_POWERDOWN_N <= 1'b0;
      DLL_CODE_UPDATE <= 1'b0;
      READY           <= 1'b0;
      CODE_OUT        <= 8'h00;
      CODE_VALID      <= 1'b0;
      ERROR           <= 1'b0;
      RETRY_CNT       <= 2'd0;
    end else begin
      state_q         <= state_d;
      lock_s1         <= DLL_LOCK;
      lock_sync       <= lock_s1;
      diff_s1         <= DLL_DELAY_DIFF;
      diff_sync       <= diff_s1;
      code_s          <= DLL_CODE;
      code_p          <= code_s;
      tmr_q           <= tmr_d;
      filt_q          <= filt_d;
      DLL_POWERDOWN_N <= pdn_d;
      DLL_CODE_UPDATE <= upd_d;
      READY           <= rdy_d;
      CODE_OUT        <= code_out_d;
      CODE_VALID      <= code_valid_d;
      ERROR           <= err_d;
      RETRY_CNT       <= retry_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_ddr4_dll_lock_ctrl.sv
// Bench for ddr4_dll_lock_ctrl: table of timed input/expected-output vectors through a
// scoreboard queue, plus hand-written multi-cycle sequences for retry/fail/capture corners.
module tb_ddr4_dll_lock_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       FORCE_UPDATE = 1'b0;
  logic       DLL_LOCK = 1'b0;
  logic       DLL_DELAY_DIFF = 1'b0;
  logic [7:0] DLL_CODE = 8'h00;
  logic       DLL_POWERDOWN_N, DLL_CODE_UPDATE, READY, CODE_VALID, ERROR;
  logic [7:0] CODE_OUT;
  logic [1:0] RETRY_CNT;
  logic [2:0] STATE;

  ddr4_dll_lock_ctrl #(
    .PWRUP_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .UPDATE_INTERVAL(16)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .FORCE_UPDATE(FORCE_UPDATE),
    .DLL_LOCK(DLL_LOCK),
    .DLL_DELAY_DIFF(DLL_DELAY_DIFF),
    .DLL_CODE(DLL_CODE),
    .DLL_POWERDOWN_N(DLL_POWERDOWN_N),
    .DLL_CODE_UPDATE(DLL_CODE_UPDATE),
    .READY(READY),
    .CODE_OUT(CODE_OUT),
    .CODE_VALID(CODE_VALID),
    .ERROR(ERROR),
    .RETRY_CNT(RETRY_CNT),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       pdn;
    logic       upd;
    logic       rdy;
    logic       vld;
    logic       err;
    logic [1:0] rc;
    logic [7:0] co;
  } exp_t;

  typedef struct {
    logic       rst, en, frc, lock, diff;
    logic [7:0] code;
    int         n;
    exp_t       exp;
  } vec_t;

  vec_t vecs[13];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   vld_cnt = 0;
  int   upd_cnt = 0;

  function automatic vec_t mk(input logic rst, input logic en, input logic frc,
                              input logic lock, input logic diff, input logic [7:0] code,
                              input int n, input logic [2:0] st, input logic pdn,
                              input logic upd, input logic rdy, input logic vld,
                              input logic err, input logic [1:0] rc, input logic [7:0] co);
    vec_t v;
    v.rst = rst; v.en = en; v.frc = frc; v.lock = lock; v.diff = diff;
    v.code = code; v.n = n;
    v.exp = {st, pdn, upd, rdy, vld, err, rc, co};
    return v;
  endfunction

  function automatic exp_t actual();
    return {STATE, DLL_POWERDOWN_N, DLL_CODE_UPDATE, READY, CODE_VALID, ERROR, RETRY_CNT, CODE_OUT};
  endfunction

  // Advance on negedges, counting the single-cycle outputs as they are seen.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (CODE_VALID) vld_cnt++;
      if (DLL_CODE_UPDATE) upd_cnt++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    exp_t e, a;
    RESET = vecs[i].rst;
    ENABLE = vecs[i].en;
    FORCE_UPDATE = vecs[i].frc;
    DLL_LOCK = vecs[i].lock;
    DLL_DELAY_DIFF = vecs[i].diff;
    DLL_CODE = vecs[i].code;
    exp_q.push_back(vecs[i].exp);
    tick(1);
    FORCE_UPDATE = 1'b0;
    tick(vecs[i].n - 1);
    e = exp_q.pop_front();
    a = actual();
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL vec%0d: got st=%0d pdn=%0b upd=%0b rdy=%0b vld=%0b err=%0b rc=%0d co=%02h expected st=%0d pdn=%0b upd=%0b rdy=%0b vld=%0b err=%0b rc=%0d co=%02h",
               i, a.st, a.pdn, a.upd, a.rdy, a.vld, a.err, a.rc, a.co,
               e.st, e.pdn, e.upd, e.rdy, e.vld, e.err, e.rc, e.co);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  initial begin
    int k;
    int v0;
    //          rst en frc lk df code   n   st pdn upd rdy vld err rc co
    vecs[0]  = mk(1, 0, 0, 0, 0, 8'h00, 2,  0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(0, 1, 0, 1, 0, 8'h5A, 4,  1, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[2]  = mk(0, 1, 0, 1, 0, 8'h5A, 1,  2, 1, 0, 0, 0, 0, 0, 8'h00);
    vecs[3]  = mk(0, 1, 0, 1, 0, 8'h5A, 8,  5, 1, 0, 0, 0, 0, 0, 8'h00);
    vecs[4]  = mk(0, 1, 0, 1, 0, 8'h5A, 2,  3, 1, 0, 1, 1, 0, 0, 8'h5A);
    vecs[5]  = mk(0, 1, 0, 1, 0, 8'h5A, 1,  3, 1, 0, 1, 0, 0, 0, 8'h5A);
    vecs[6]  = mk(0, 1, 0, 1, 1, 8'h60, 14, 3, 1, 0, 1, 0, 0, 0, 8'h5A);
    vecs[7]  = mk(0, 1, 0, 1, 1, 8'h60, 1,  4, 1, 1, 0, 0, 0, 0, 8'h5A);
    vecs[8]  = mk(0, 1, 0, 1, 1, 8'h60, 4,  5, 1, 0, 0, 0, 0, 0, 8'h5A);
    vecs[9]  = mk(0, 1, 0, 1, 1, 8'h60, 2,  3, 1, 0, 1, 1, 0, 0, 8'h60);
    vecs[10] = mk(0, 1, 0, 1, 0, 8'h60, 1,  3, 1, 0, 1, 0, 0, 0, 8'h60);
    // Lock dropped two cycles ahead so FORCE_UPDATE meets it after the synchronizer.
    vecs[11] = mk(0, 1, 0, 0, 0, 8'h60, 2,  3, 1, 0, 1, 0, 0, 0, 8'h60);
    vecs[12] = mk(0, 1, 1, 0, 0, 8'h60, 1,  1, 0, 0, 0, 0, 0, 1, 8'h60);

    // Power-up, lock, capture, then interval-driven update with a new code.
    run_vecs(0, 9);
    check("interval_update_width", upd_cnt, 4);
    check("code_valid_pulses", vld_cnt, 2);
    run_vecs(10, 10);

    // Forced update followed by a code that never settles: capture times out.
    v0 = vld_cnt;
    FORCE_UPDATE = 1'b1;
    tick(1);
    FORCE_UPDATE = 1'b0;
    check("force_to_update", int'(STATE), 4);
    for (int i = 0; i < 20; i++) begin
      DLL_CODE = 8'(8'h80 + i);
      tick(1);
      if (i == 3) check("capture_entered", int'(STATE), 5);
      if (i == 18) check("capture_held", int'(STATE), 5);
    end
    check("capture_timeout_state", int'(STATE), 3);
    check("capture_timeout_code", int'(CODE_OUT), 'h60);
    check("capture_timeout_no_valid", vld_cnt, v0);
    check("force_update_width", upd_cnt, 8);
    DLL_CODE = 8'h60;

    // Lock loss coinciding with FORCE_UPDATE.
    run_vecs(11, 12);
    check("lockloss_no_update", upd_cnt, 8);

    // Lock toggling 1,1,1,0 never qualifies; timeout retry after 32 WAIT_LOCK cycles.
    for (int i = 0; i < 36; i++) begin
      DLL_LOCK = 1'(i % 4 != 3);
      tick(1);
      if (i == 34) check("toggle_still_waiting", int'(STATE), 2);
    end
    check("toggle_retry_state", int'(STATE), 1);
    check("toggle_retry_cnt", int'(RETRY_CNT), 2);

    // Lock stuck low: last retry, then FAIL.
    DLL_LOCK = 1'b0;
    k = 0;
    while (RETRY_CNT != 2'd3 && k < 200) begin tick(1); k++; end
    check("stuck_retry3_seen", int'(k < 200), 1);
    check("stuck_retry3_pwrup", int'(STATE), 1);
    check("stuck_retry3_pdn", int'(DLL_POWERDOWN_N), 0);
    k = 0;
    while (!ERROR && k < 200) begin tick(1); k++; end
    check("fail_seen", int'(k < 200), 1);
    check("fail_state", int'(STATE), 6);
    check("fail_pdn", int'(DLL_POWERDOWN_N), 0);
    check("fail_ready", int'(READY), 0);
    check("fail_retry", int'(RETRY_CNT), 3);
    DLL_LOCK = 1'b1;
    tick(12);
    check("fail_sticky", int'(STATE), 6);

    // ENABLE low then high restarts from OFF and relocks.
    ENABLE = 1'b0;
    tick(1);
    check("disable_off", int'(STATE), 0);
    check("disable_retry_clr", int'(RETRY_CNT), 0);
    check("disable_error_clr", int'(ERROR), 0);
    check("disable_code_kept", int'(CODE_OUT), 'h60);
    ENABLE = 1'b1;
    DLL_CODE = 8'h33;
    tick(1);
    check("reenable_pwrup", int'(STATE), 1);
    k = 0;
    while (!READY && k < 100) begin tick(1); k++; end
    check("relock_seen", int'(k < 100), 1);
    check("relock_code", int'(CODE_OUT), 'h33);
    check("relock_retry", int'(RETRY_CNT), 0);

    // Reset in the middle of operation.
    RESET = 1'b1;
    tick(1);
    check("midreset_state", int'(STATE), 0);
    check("midreset_code", int'(CODE_OUT), 0);
    check("midreset_ready", int'(READY), 0);
    check("midreset_pdn", int'(DLL_POWERDOWN_N), 0);
    RESET = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
